// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with EX/MEM and MEM/WB operand forwarding, stall refresh and illegal-opcode flag
module id_ex_operand_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic [4:0]    id_alu_op,
  input  logic          id_inv_a,
  input  logic          id_inv_b,
  input  logic          id_cin,
  input  logic          id_sign,
  input  logic          exmem_reg_write,
  input  logic          exmem_valid,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic          memwb_valid,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_op,
  output logic          alu_inv_a,
  output logic          alu_inv_b,
  output logic          alu_cin,
  output logic          alu_sign,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_op_err,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel
);
  logic          v, use_imm_q, rw_q, err_q, inv_a_q, inv_b_q, cin_q, sign_q;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic [DW-1:0] a_q, b_q;
  logic [4:0]    op_q;
  logic          hit_ea, hit_wa, hit_eb, hit_wb, illegal;
  // operand forwarding from the registered indices; EX/MEM beats MEM/WB, immediates never forward
  always_comb begin
    hit_ea    = exmem_valid & exmem_reg_write & (exmem_rd == rs_q);
    hit_wa    = memwb_valid & memwb_reg_write & (memwb_rd == rs_q);
    hit_eb    = ~use_imm_q & exmem_valid & exmem_reg_write & (exmem_rd == rt_q);
    hit_wb    = ~use_imm_q & memwb_valid & memwb_reg_write & (memwb_rd == rt_q);
    fwd_a_sel = hit_ea ? 2'b01 : hit_wa ? 2'b10 : 2'b00;
    fwd_b_sel = hit_eb ? 2'b01 : hit_wb ? 2'b10 : 2'b00;
    alu_a     = hit_ea ? exmem_result : hit_wa ? memwb_result : a_q;
    alu_b     = hit_eb ? exmem_result : hit_wb ? memwb_result : b_q;
    illegal   = id_alu_op[4] & (|id_alu_op[3:0]);
  end
  // stage register: reset, then flush (bubble), then stall (hold but capture forwarded operands), else load
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      use_imm_q <= 1'b0;
      op_q      <= '0;
      inv_a_q   <= 1'b0;
      inv_b_q   <= 1'b0;
      cin_q     <= 1'b0;
      sign_q    <= 1'b0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
    end else if (flush) begin
      v     <= 1'b0;
      rw_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (stall) begin
      a_q <= alu_a;
      b_q <= alu_b;
    end else begin
      v         <= id_valid;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      a_q       <= id_rs_data;
      b_q       <= id_use_imm ? id_imm : id_rt_data;
      use_imm_q <= id_use_imm;
      op_q      <= id_alu_op;
      inv_a_q   <= id_inv_a;
      inv_b_q   <= id_inv_b;
      cin_q     <= id_cin;
      sign_q    <= id_sign;
      rd_q      <= id_rd;
      rw_q      <= id_reg_write & id_valid;
      err_q     <= illegal & id_valid;
    end
  end
  assign ex_valid     = v;
  assign alu_op       = op_q;
  assign alu_inv_a    = inv_a_q;
  assign alu_inv_b    = inv_b_q;
  assign alu_cin      = cin_q;
  assign alu_sign     = sign_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = rw_q;
  assign ex_op_err    = err_q;
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage between decode and the ALU in the 16-bit five-stage core. It registers decoded operands and ALU control (`Op`, `invA`, `invB`, `Cin`, `sign`), applies EX/MEM and MEM/WB forwarding to the registered operands, and drives the ALU `A`/`B` inputs. It supports hazard-unit stall and flush, and flags ALU opcodes the ALU does not implement.

## Interface
Parameters:
- `DW`, 16: datapath width.
- `RW`, 3: register index width (8 GPRs; R0 is an ordinary register).

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold the stage contents.
- `flush`  in  1: squash the stage contents (insert a bubble).
- `id_valid`  in  1: the decode slot holds a real instruction.
- `id_rs_data`, `id_rt_data`  in  DW: register-file read data.
- `id_imm`  in  DW: sign- or zero-extended immediate, already extended by decode.
- `id_use_imm`  in  1: B operand comes from `id_imm` instead of rt.
- `id_rs`, `id_rt`, `id_rd`  in  RW: register indices.
- `id_reg_write`  in  1: instruction writes `id_rd`.
- `id_alu_op`  in  5: ALU opcode.
- `id_inv_a`, `id_inv_b`, `id_cin`, `id_sign`  in  1: ALU controls.
- `exmem_reg_write`, `exmem_valid`  in  1: EX/MEM producer status.
- `exmem_rd`  in  RW: EX/MEM destination register.
- `exmem_result`  in  DW: EX/MEM result value.
- `memwb_reg_write`, `memwb_valid`  in  1: MEM/WB producer status.
- `memwb_rd`  in  RW: MEM/WB destination register.
- `memwb_result`  in  DW: MEM/WB result value.
- `ex_valid`  out  1: registered valid.
- `alu_a`, `alu_b`  out  DW: forwarded ALU operands (combinational from the registers).
- `alu_op`  out  5: registered ALU opcode.
- `alu_inv_a`, `alu_inv_b`, `alu_cin`, `alu_sign`  out  1: registered ALU controls.
- `ex_rd`  out  RW: registered destination index.
- `ex_reg_write`  out  1: registered `id_reg_write & id_valid`.
- `ex_op_err`  out  1: registered illegal-opcode flag, qualified by valid.
- `fwd_a_sel`, `fwd_b_sel`  out  2: forwarding select. 00 = register, 01 = EX/MEM, 10 = MEM/WB.

## Operation
Field capture:
- The stage holds the registered fields `v`, `rs_q`, `rt_q`, `a_q`, `b_q`, `use_imm_q`, control, `rd_q`, `rw_q`, and `err_q`.
- `a_q` comes from `id_rs_data`.
- `b_q` comes from `id_imm` when `id_use_imm`=1, otherwise from `id_rt_data`.

Edge update priority (highest first):
1. `rst`: every register is cleared to 0.
2. `flush`: `v`, `rw_q` and `err_q` are cleared. Other fields are don't-care but must not propagate a write. `flush` overrides `stall`.
3. `stall`: all fields are held, except the operand refresh below.
4. Otherwise: all fields load from the `id_*` inputs. `v` = `id_valid`; `rw_q` = `id_reg_write & id_valid`.

Forwarding (combinational, on the registered indices; the A side is shown, the B side is identical using `rt_q`):
- Condition for the B side: B forwards only when `use_imm_q`=0; otherwise `fwd_b_sel`=00 and `alu_b`=`b_q`.
- `hitE` = `exmem_valid & exmem_reg_write & (exmem_rd == rs_q)`.
- `hitW` = `memwb_valid & memwb_reg_write & (memwb_rd == rs_q)`.
- Select:
  - `hitE`: `fwd_a_sel`=01, `alu_a`=`exmem_result`.
  - else `hitW`: `fwd_a_sel`=10, `alu_a`=`memwb_result`.
  - else: `fwd_a_sel`=00, `alu_a`=`a_q`.
- EX/MEM always wins over MEM/WB.
- Forwarding is evaluated even when `v`=0. Outputs are don't-care in that case, but the selects must still be deterministic.

Stall refresh:
- While `stall`=1 and `flush`=0, `a_q` (and `b_q` when `use_imm_q`=0) is overwritten with the current forwarded value `alu_a`/`alu_b`.
- This keeps the value correct after the producer retires past MEM/WB during a multi-cycle stall.

Illegal opcode:
- Legal `alu_op` values are 00000–01111 and 10000.
- 10001–11111 are illegal: `err_q` = `id_valid & illegal`.
- The ALU's own error output is not relied on.

## Timing
- Latency: 1 cycle from the `id_*` inputs to the registered outputs. Forwarding adds no cycle.
- Reset values of the registered outputs:
  - `ex_valid`=0, `alu_op`=00000, all controls 0, `ex_rd`=0, `ex_reg_write`=0, `ex_op_err`=0.
- Reset values of the combinational outputs, with no forwarding hits:
  - `alu_a`=`alu_b`=0x0000.
  - `fwd_a_sel`=`fwd_b_sel`=00.
- Reset mid-stall discards the held instruction. The next cycle after `rst` deasserts behaves as an unstalled load.
- `stall` and `flush` in the same cycle: flush wins and the stage becomes a bubble.
- A bubble (`ex_valid`=0) never asserts `ex_reg_write` or `ex_op_err`.
- No combinational path from `stall`/`flush` to any output.

## Test plan
- Reset and load:
  - Assert `rst` for 2 cycles: all outputs are 0.
  - Load rs_data=0x1234, rt_data=0x00FF, op=00101, rd=3, rw=1: next cycle `alu_a`=0x1234, `alu_b`=0x00FF, `alu_op`=00101, `ex_reg_write`=1.
- Forward priority:
  - Setup: rs_q=2; exmem_rd=2 with result 0xAAAA; memwb_rd=2 with result 0x5555; both valid and writing.
  - Required: `alu_a`=0xAAAA, `fwd_a_sel`=01.
  - Drop `exmem_reg_write`: `alu_a`=0x5555, `fwd_a_sel`=10.
- Immediate suppresses the B forward:
  - Setup: `id_use_imm`=1, imm=0xFFF0, rt=4, exmem_rd=4 writing 0x0001.
  - Required: `alu_b`=0xFFF0, `fwd_b_sel`=00.
- Stall refresh:
  - Setup: stall 3 cycles with rs_q=5. Cycle 1: memwb_rd=5 writes 0x0BEE. Cycles 2–3: no hits.
  - Required: `alu_a` stays 0x0BEE through cycle 3 and after the stall releases; other fields are unchanged.
- Flush vs stall:
  - `stall`=`flush`=1 with a valid instruction held: next cycle `ex_valid`=0, `ex_reg_write`=0.
  - Reset mid-stall: all outputs return to 0.
- Illegal opcode:
  - op=10011 with valid=1: `ex_op_err`=1.
  - op=10000: `ex_op_err`=0.
  - op=10011 with valid=0: `ex_op_err`=0.
